// File: rtl/mmio_uart_tx.sv
// I/O page peripheral on the CPU memory bus: LED register, status word and an 8N1 UART transmitter.
// Reads have one cycle of latency; TXD idles high.
module mmio_uart_tx #(
    parameter int BAUD_DIV = 104,
    parameter int IO_BIT   = 22
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    input  logic        mem_rstrb,
    output logic [31:0] io_rdata,
    output logic [3:0]  leds,
    output logic        txd
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    state_t      state, state_n;
    logic [9:0]  shift, shift_n;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [15:0] baud_cnt, baud_cnt_n;
    logic        overrun;
    logic        busy;

    logic        io_sel;
    logic [1:0]  word;
    logic        wr_en, rd_en;
    logic        led_wr, data_wr, stat_rd;
    logic [31:0] rd_word;
    logic        unused;

    assign io_sel  = mem_addr[IO_BIT];
    assign word    = mem_addr[3:2];
    assign wr_en   = io_sel && mem_wmask[0];
    assign rd_en   = io_sel && mem_rstrb;
    assign led_wr  = wr_en && (word == 2'd0);
    assign data_wr = wr_en && (word == 2'd1);
    assign stat_rd = rd_en && (word == 2'd2);
    assign busy    = (state == SEND);
    assign unused  = ^{mem_addr, mem_wdata[31:8], mem_wmask[3:1]};

    // Mux sees register values before any same-cycle write lands.
    always_comb begin
        rd_word = '0;
        case (word)
            2'd0:    rd_word = {28'b0, leds};
            2'd2:    rd_word = {22'b0, overrun, busy, 8'b0};
            default: rd_word = '0;
        endcase
    end

    always_comb begin
        state_n    = state;
        shift_n    = shift;
        bit_cnt_n  = bit_cnt;
        baud_cnt_n = baud_cnt;
        txd        = 1'b1;
        case (state)
            IDLE: begin
                if (data_wr) begin
                    state_n    = SEND;
                    shift_n    = {1'b1, mem_wdata[7:0], 1'b0};
                    bit_cnt_n  = '0;
                    baud_cnt_n = '0;
                end
            end
            SEND: begin
                txd = shift[0];
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt_n = '0;
                    shift_n    = shift >> 1;
                    bit_cnt_n  = bit_cnt + 4'd1;
                    // Last baud tick of the stop bit ends the frame.
                    if (bit_cnt == 4'd9)
                        state_n = IDLE;
                end else begin
                    baud_cnt_n = baud_cnt + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            bit_cnt  <= bit_cnt_n;
            baud_cnt <= baud_cnt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            leds     <= '0;
            io_rdata <= '0;
            overrun  <= 1'b0;
        end else begin
            if (led_wr)
                leds <= mem_wdata[3:0];
            if (rd_en)
                io_rdata <= rd_word;
            // A dropped write outranks a clearing status read.
            if (data_wr && busy)
                overrun <= 1'b1;
            else if (stat_rd)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with BAUD_DIV=4: register-access vector table plus UART frame sequences.
module tb_mmio_uart_tx;

    localparam int BAUD = 4;
    localparam logic [31:0] IO = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wmask = '0;
    logic        mem_rstrb = 1'b0;
    logic [31:0] io_rdata;
    logic [3:0]  leds;
    logic        txd;

    int errors = 0;
    int checks = 0;

    mmio_uart_tx #(.BAUD_DIV(BAUD), .IO_BIT(22)) dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .io_rdata(io_rdata),
        .leds(leds), .txd(txd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        rstrb;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_leds;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input logic r);
        mem_addr = a; mem_wdata = d; mem_wmask = m; mem_rstrb = r;
    endtask

    task automatic bus_idle();
        drive('0, '0, '0, 1'b0);
    endtask

    task automatic start_write(input logic [7:0] b);
        drive(IO | 32'h4, {24'hABCDEF, b}, 4'b0001, 1'b0);
        tick();
        bus_idle();
    endtask

    // Checks samples 0..39 of a frame and the first idle sample (40); returns at sample 40.
    task automatic check_frame(input logic [7:0] b, input int wr_at, input logic [7:0] wr_b,
                               input int rd_at, input logic [31:0] exp_rd);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 10*BAUD; i++) begin
            chk($sformatf("txd[%0d] byte %h", i, b), {31'b0, txd}, {31'b0, bits[i/BAUD]});
            chk($sformatf("busy[%0d]", i), {31'b0, dut.busy}, 32'd1);
            if (i == wr_at) drive(IO | 32'h4, {24'h0, wr_b}, 4'b0001, 1'b0);
            if (i == rd_at) drive(IO | 32'h8, '0, 4'b0000, 1'b1);
            tick();
            bus_idle();
            if (i == rd_at) chk("status read mid-frame", io_rdata, exp_rd);
        end
        chk("txd idle after frame", {31'b0, txd}, 32'd1);
        chk("busy low after frame", {31'b0, dut.busy}, 32'd0);
    endtask

    task automatic status_read(input string name, input logic [31:0] exp);
        drive(IO | 32'h8, '0, 4'b0000, 1'b1);
        tick();
        bus_idle();
        chk(name, io_rdata, exp);
    endtask

    initial begin
        vecs[0]  = '{IO | 32'h8, 32'h0,         4'b0000, 1'b1, 32'h0, 4'h0};
        vecs[1]  = '{IO | 32'h0, 32'hFFFF_FFF9, 4'b0001, 1'b0, 32'h0, 4'h9};
        vecs[2]  = '{IO | 32'h0, 32'h0,         4'b0000, 1'b1, 32'h9, 4'h9};
        vecs[3]  = '{IO | 32'h0, 32'h0000_0005, 4'b0010, 1'b0, 32'h9, 4'h9};
        vecs[4]  = '{32'h0,      32'h0000_0003, 4'b0001, 1'b0, 32'h9, 4'h9};
        vecs[5]  = '{32'h0,      32'h0,         4'b0000, 1'b1, 32'h9, 4'h9};
        vecs[6]  = '{IO | 32'h4, 32'h0,         4'b0000, 1'b1, 32'h0, 4'h9};
        vecs[7]  = '{IO | 32'h0, 32'h0,         4'b0000, 1'b1, 32'h9, 4'h9};
        vecs[8]  = '{IO | 32'hC, 32'hFFFF_FFFF, 4'b1111, 1'b1, 32'h0, 4'h9};
        vecs[9]  = '{IO | 32'h0, 32'h0000_0002, 4'b0001, 1'b1, 32'h9, 4'h2};
        vecs[10] = '{IO | 32'h0, 32'h0,         4'b0000, 1'b1, 32'h2, 4'h2};
        vecs[11] = '{IO | 32'h0, 32'h0000_0009, 4'b0001, 1'b0, 32'h2, 4'h9};

        tick(); tick();
        reset = 1'b0;
        chk("reset txd", {31'b0, txd}, 32'd1);
        chk("reset leds", {28'b0, leds}, 32'h0);
        chk("reset io_rdata", io_rdata, 32'h0);
        chk("reset busy", {31'b0, dut.busy}, 32'd0);

        for (int v = 0; v < 12; v++) begin
            drive(vecs[v].addr, vecs[v].wdata, vecs[v].wmask, vecs[v].rstrb);
            tick();
            bus_idle();
            chk($sformatf("vec%0d io_rdata", v), io_rdata, vecs[v].exp_rdata);
            chk($sformatf("vec%0d leds", v), {28'b0, leds}, {28'b0, vecs[v].exp_leds});
        end

        // Plain frame.
        start_write(8'h55);
        check_frame(8'h55, -1, 8'h0, -1, 32'h0);
        status_read("status after 0x55", 32'h0);

        // Overrun mid-frame: 0x55 continues, 0xA3 is dropped.
        start_write(8'h55);
        check_frame(8'h55, 15, 8'hA3, 20, 32'h300);
        status_read("status after overrun frame", 32'h0);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("no dropped frame txd[%0d]", i), {31'b0, txd}, 32'd1);
            chk($sformatf("no dropped frame busy[%0d]", i), {31'b0, dut.busy}, 32'd0);
            tick();
        end

        // Back-to-back: second write on the first idle cycle.
        start_write(8'h0F);
        check_frame(8'h0F, -1, 8'h0, -1, 32'h0);
        start_write(8'hF0);
        check_frame(8'hF0, -1, 8'h0, -1, 32'h0);
        status_read("overrun stays clear b2b", 32'h0);

        // Reset mid-frame.
        start_write(8'h33);
        for (int i = 0; i < 15; i++) tick();
        chk("frame running before reset", {31'b0, dut.busy}, 32'd1);
        reset = 1'b1;
        tick();
        chk("mid-frame reset txd", {31'b0, txd}, 32'd1);
        chk("mid-frame reset busy", {31'b0, dut.busy}, 32'd0);
        chk("mid-frame reset leds", {28'b0, leds}, 32'h0);
        reset = 1'b0;
        tick();
        chk("txd idle after reset", {31'b0, txd}, 32'd1);
        start_write(8'hC5);
        check_frame(8'hC5, -1, 8'h0, -1, 32'h0);
        status_read("status after post-reset frame", 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
